// File: rtl/max7219_spi_rx.sv
// MAX7219 receiver model: oversamples DIN/CLK/CS, assembles 16-bit words and decodes them into the register file.
// Optional build macro MAX7219_DOUT_EN enables the daisy-chain output on spi_dout.
module max7219_spi_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_W     = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               spi_din,
    input  logic               spi_clk,
    input  logic               spi_cs,
    output logic               spi_dout,
    output logic [FRAME_W-1:0] frame,
    output logic [7:0]         decode_mode,
    output logic [3:0]         intensity,
    output logic [2:0]         scan_limit,
    output logic               shutdown_n,
    output logic               display_test,
    output logic               word_valid,
    output logic [3:0]         word_addr,
    output logic [7:0]         word_data,
    output logic               frame_err
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t                 state;
    logic [15:0]            sreg;
    logic [4:0]             bitcnt;
    logic [SYNC_STAGES-1:0] din_sync_q;
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;
    logic                   din_s;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   sclk_rise;
    logic                   cs_fall;
    logic                   cs_rise;
    logic [2:0]             row;

    // CS resets to the low sample so a frame already in progress at reset release never shows a cs_fall.
    // NOTE: every flop here uses non-blocking assignment so all registers update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_sync_q  <= '0;
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], spi_din};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // Digit registers 1..8 map to rows 0..7; address 8 wraps to row 7 through the 3-bit subtract.
    assign row = sreg[10:8] - 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sreg         <= '0;
            bitcnt       <= '0;
            frame        <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
            word_valid   <= 1'b0;
            word_addr    <= '0;
            word_data    <= '0;
            frame_err    <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state  <= SHIFT;
                        sreg   <= '0;
                        bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    // A bit arriving in the same cycle as the CS rise belongs to no word.
                    if (cs_rise) begin
                        state <= COMMIT;
                    end else if (sclk_rise) begin
                        sreg <= {sreg[14:0], din_s};
                        if (bitcnt != 5'd31) begin
                            bitcnt <= bitcnt + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    if (bitcnt >= 5'd16) begin
                        word_valid <= 1'b1;
                        word_addr  <= sreg[11:8];
                        word_data  <= sreg[7:0];
                        case (sreg[11:8])
                            4'h1, 4'h2, 4'h3, 4'h4,
                            4'h5, 4'h6, 4'h7, 4'h8: frame[{row, 3'b000} +: 8] <= sreg[7:0];
                            4'h9: decode_mode  <= sreg[7:0];
                            4'hA: intensity    <= sreg[3:0];
                            4'hB: scan_limit   <= sreg[2:0];
                            4'hC: shutdown_n   <= sreg[0];
                            4'hF: display_test <= sreg[0];
                            default: ;
                        endcase
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MAX7219_DOUT_EN
    logic sclk_fall;

    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // Presenting sreg[15] on the falling edge delays each bit by exactly 16 SPI clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spi_dout <= 1'b0;
        end else if (state == IDLE) begin
            spi_dout <= 1'b0;
        end else if (state == SHIFT && sclk_fall) begin
            spi_dout <= sreg[15];
        end
    end
`else
    logic unused_sreg_msb;

    assign unused_sreg_msb = sreg[15];
    assign spi_dout        = 1'b0;
`endif

endmodule

// File: tb/tb_max7219_spi_rx.sv
// Self-checking bench for max7219_spi_rx: drives SPI frames, scoreboards accepted words and
// compares the register file against a small behavioural model.
module tb_max7219_spi_rx;

    logic        clk;
    logic        rst_n;
    logic        spi_din;
    logic        spi_clk;
    logic        spi_cs;
    logic        spi_dout;
    logic [63:0] frame;
    logic [7:0]  decode_mode;
    logic [3:0]  intensity;
    logic [2:0]  scan_limit;
    logic        shutdown_n;
    logic        display_test;
    logic        word_valid;
    logic [3:0]  word_addr;
    logic [7:0]  word_data;
    logic        frame_err;

    int          vectors;
    int          miscompares;
    logic [11:0] exp_q[$];
    logic [31:0] dout_cap;

    logic [63:0] m_frame;
    logic [7:0]  m_decode;
    logic [3:0]  m_int;
    logic [2:0]  m_scan;
    logic        m_shut;
    logic        m_test;

    max7219_spi_rx #(.SYNC_STAGES(2), .FRAME_W(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_din      (spi_din),
        .spi_clk      (spi_clk),
        .spi_cs       (spi_cs),
        .spi_dout     (spi_dout),
        .frame        (frame),
        .decode_mode  (decode_mode),
        .intensity    (intensity),
        .scan_limit   (scan_limit),
        .shutdown_n   (shutdown_n),
        .display_test (display_test),
        .word_valid   (word_valid),
        .word_addr    (word_addr),
        .word_data    (word_data),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_frame  = '0;
        m_decode = '0;
        m_int    = '0;
        m_scan   = '0;
        m_shut   = 1'b0;
        m_test   = 1'b0;
    endtask

    task automatic model_apply(input logic [15:0] w);
        logic [3:0] a;
        logic [7:0] d;
        a = w[11:8];
        d = w[7:0];
        if (a >= 4'h1 && a <= 4'h8) m_frame[(int'(a) - 1) * 8 +: 8] = d;
        else if (a == 4'h9) m_decode = d;
        else if (a == 4'hA) m_int = d[3:0];
        else if (a == 4'hB) m_scan = d[2:0];
        else if (a == 4'hC) m_shut = d[0];
        else if (a == 4'hF) m_test = d[0];
    endtask

    // One SPI bit: data set up well before the rising edge, dout sampled just before it.
    task automatic shift_bit(input logic b);
        spi_din = b;
        repeat (5) @(negedge clk);
        dout_cap = {dout_cap[30:0], spi_dout};
        spi_clk = 1'b1;
        repeat (5) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    // Sends the n LSBs of val MSB first inside one CS window, then scoreboards the resulting word.
    task automatic spi_frame(input logic [31:0] val, input int n, output int n_valid, output int n_err);
        logic [11:0] e;
        spi_cs = 1'b0;
        dout_cap = '0;
        repeat (5) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) shift_bit(val[i]);
        repeat (5) @(negedge clk);
        if (n >= 16) begin
            exp_q.push_back(val[11:0]);
            model_apply(val[15:0]);
        end
        spi_cs = 1'b1;
        n_valid = 0;
        n_err = 0;
        repeat (12) begin
            @(negedge clk);
            if (word_valid) begin
                n_valid++;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_word: got %h, none expected", {word_addr, word_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({word_addr, word_data} !== e) begin
                        miscompares++;
                        $display("FAIL word: got %h expected %h", {word_addr, word_data}, e);
                    end
                end
            end
            if (frame_err) n_err++;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_word: %0d expected words never appeared", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({spi_dout, frame, decode_mode, intensity, scan_limit, shutdown_n, display_test,
             word_valid, word_addr, word_data, frame_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: regs %h valid %b err %b dout %b expected all zero",
                     {frame, decode_mode, intensity, scan_limit, shutdown_n, display_test},
                     word_valid, frame_err, spi_dout);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_init();
        logic [15:0] words[7];
        int nv;
        int ne;
        int total;
        words = '{16'h0900, 16'h0A03, 16'h0B07, 16'h0C01, 16'h0F00, 16'h01AA, 16'h0255};
        total = 0;
        foreach (words[i]) begin
            spi_frame({16'h0, words[i]}, 16, nv, ne);
            total += nv;
        end
        vectors++;
        if (total !== 7) begin
            miscompares++;
            $display("FAIL init_count: got %0d word_valid pulses expected 7", total);
        end
        vectors++;
        if ({decode_mode, intensity, scan_limit, shutdown_n, display_test, frame[15:0]} !==
            {8'h00, 4'h3, 3'h7, 1'b1, 1'b0, 16'h55AA}) begin
            miscompares++;
            $display("FAIL init_regs: got %h expected %h",
                     {decode_mode, intensity, scan_limit, shutdown_n, display_test, frame[15:0]},
                     {8'h00, 4'h3, 3'h7, 1'b1, 1'b0, 16'h55AA});
        end
        vectors++;
        if ({frame, decode_mode, intensity, scan_limit, shutdown_n, display_test} !==
            {m_frame, m_decode, m_int, m_scan, m_shut, m_test}) begin
            miscompares++;
            $display("FAIL init_model: got %h expected %h",
                     {frame, decode_mode, intensity, scan_limit, shutdown_n, display_test},
                     {m_frame, m_decode, m_int, m_scan, m_shut, m_test});
        end
    endtask

    task automatic test_short_frame();
        int nv;
        int ne;
        spi_frame(32'h0000_0C00, 12, nv, ne);
        vectors++;
        if (ne !== 1 || nv !== 0) begin
            miscompares++;
            $display("FAIL short_frame: got err %0d valid %0d expected err 1 valid 0", ne, nv);
        end
        vectors++;
        if ({frame, decode_mode, intensity, scan_limit, shutdown_n, display_test} !==
            {m_frame, m_decode, m_int, m_scan, m_shut, m_test}) begin
            miscompares++;
            $display("FAIL short_regs: got %h expected %h",
                     {frame, decode_mode, intensity, scan_limit, shutdown_n, display_test},
                     {m_frame, m_decode, m_int, m_scan, m_shut, m_test});
        end
    endtask

    task automatic test_long_frame();
        int nv;
        int ne;
        logic [31:0] exp_dout;
        spi_frame(32'h0A05_0B02, 32, nv, ne);
        vectors++;
        if (scan_limit !== 3'd2 || intensity !== 4'd3 || ne !== 0) begin
            miscompares++;
            $display("FAIL long_frame: got scan %0d int %0d err %0d expected scan 2 int 3 err 0",
                     scan_limit, intensity, ne);
        end
`ifdef MAX7219_DOUT_EN
        exp_dout = 32'h0000_0A05;
`else
        exp_dout = 32'h0000_0000;
`endif
        vectors++;
        if (dout_cap !== exp_dout) begin
            miscompares++;
            $display("FAIL long_dout: got %h expected %h", dout_cap, exp_dout);
        end
    endtask

    task automatic test_ignored_addr();
        int nv1;
        int nv2;
        int ne;
        spi_frame(32'h0000_0DFF, 16, nv1, ne);
        spi_frame(32'h0000_0000, 16, nv2, ne);
        vectors++;
        if (nv1 !== 1 || nv2 !== 1) begin
            miscompares++;
            $display("FAIL ignored_count: got %0d and %0d pulses expected 1 and 1", nv1, nv2);
        end
        vectors++;
        if ({frame, decode_mode, intensity, scan_limit, shutdown_n, display_test} !==
            {m_frame, m_decode, m_int, m_scan, m_shut, m_test}) begin
            miscompares++;
            $display("FAIL ignored_regs: got %h expected %h",
                     {frame, decode_mode, intensity, scan_limit, shutdown_n, display_test},
                     {m_frame, m_decode, m_int, m_scan, m_shut, m_test});
        end
    endtask

    task automatic test_reset_mid_frame();
        int nv;
        int ne;
        logic [7:0] hi;
        logic [7:0] lo;
        hi = 8'h08;
        lo = 8'h33;
        spi_cs = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 7; i >= 0; i--) shift_bit(hi[i]);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({spi_dout, frame, decode_mode, intensity, scan_limit, shutdown_n, display_test,
             word_valid, word_addr, word_data, frame_err} !== '0) begin
            miscompares++;
            $display("FAIL midrun_reset: regs %h valid %b err %b expected all zero",
                     {frame, decode_mode, intensity, scan_limit, shutdown_n, display_test},
                     word_valid, frame_err);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 7; i >= 0; i--) shift_bit(lo[i]);
        repeat (5) @(negedge clk);
        spi_cs = 1'b1;
        nv = 0;
        ne = 0;
        repeat (12) begin
            @(negedge clk);
            if (word_valid) nv++;
            if (frame_err) ne++;
        end
        vectors++;
        if (nv !== 0 || ne !== 0) begin
            miscompares++;
            $display("FAIL discarded_frame: got valid %0d err %0d expected 0 and 0", nv, ne);
        end
        spi_frame(32'h0000_0833, 16, nv, ne);
        vectors++;
        if (frame !== 64'h3300_0000_0000_0000 || nv !== 1) begin
            miscompares++;
            $display("FAIL after_reset_frame: got frame %h valid %0d expected %h valid 1",
                     frame, nv, 64'h3300_0000_0000_0000);
        end
        vectors++;
        if ({frame, decode_mode, intensity, scan_limit, shutdown_n, display_test} !==
            {m_frame, m_decode, m_int, m_scan, m_shut, m_test}) begin
            miscompares++;
            $display("FAIL after_reset_regs: got %h expected %h",
                     {frame, decode_mode, intensity, scan_limit, shutdown_n, display_test},
                     {m_frame, m_decode, m_int, m_scan, m_shut, m_test});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        dout_cap    = '0;
        rst_n       = 1'b0;
        spi_din     = 1'b0;
        spi_clk     = 1'b0;
        spi_cs      = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_init();
        test_short_frame();
        test_long_frame();
        test_ignored_addr();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
